fifo_pkt_reader: RTL and testbench

- Downstream consumer stage for the team's show-ahead synchronous FIFO.
- Pops words from the FIFO read port and presents them on a registered valid/ready stream, framed into fixed-length packets with first/last markers.
- If the FIFO runs dry mid-packet for too long, pads the packet to full length so downstream framing never stalls indefinitely.
- Sits between the FIFO and the packet sink (DMA or serializer).

---
 rtl/fifo_pkt_reader_if.sv | 22 ++
 rtl/fifo_pkt_reader.sv | 150 +++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_reader_if.sv
// Read port of the show-ahead FIFO and the framed output stream used by fifo_pkt_reader.
// The reader side uses the master modport of both interfaces.
interface fifo_rd_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] data;
  logic                  empty;
  logic                  rd_en;

  modport master (input data, input empty, output rd_en);
  modport slave  (output data, output empty, input rd_en);
endinterface

interface pkt_stream_if #(parameter int DATA_WIDTH = 8);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  first;
  logic                  last;
  logic                  pad;

  modport master (output valid, input ready, output data, output first, output last, output pad);
  modport slave  (input valid, output ready, input data, input first, input last, input pad);
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops a show-ahead FIFO into fixed-length packets with first/last markers, padding stalled packets.
// Define FIFO_PKT_READER_STATS_EN to build the pkt_count/pad_count statistics counters.
module fifo_pkt_reader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 4,
  parameter int                    TIMEOUT    = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(8'hA5)
) (
  input  logic        clk,
  input  logic        rst,
  fifo_rd_if.master   fifo,
  pkt_stream_if.master m,
  output logic [15:0] pkt_count,
  output logic [15:0] pad_count
);

  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [TW-1:0] TMR_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BODY, PAD} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         word_cnt, word_cnt_d;
  logic [TW-1:0]         timer, timer_d;
  logic                  out_free, pop;
  logic                  load, load_first, load_last, load_pad;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  valid_q, first_q, last_q, pad_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign out_free   = !valid_q || m.ready;
  assign pop        = !rst && (state != PAD) && out_free && !fifo.empty;
  assign fifo.rd_en = pop;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d    = state;
    word_cnt_d = word_cnt;
    timer_d    = timer;
    load       = 1'b0;
    load_first = 1'b0;
    load_last  = 1'b0;
    load_pad   = 1'b0;
    load_data  = fifo.data;
    case (state)
      IDLE: begin
        if (pop) begin
          load       = 1'b1;
          load_first = 1'b1;
          load_last  = (PKT_LEN == 1);
          timer_d    = '0;
          if (PKT_LEN == 1) begin
            word_cnt_d = '0;
          end else begin
            word_cnt_d = CW'(1);
            state_d    = BODY;
          end
        end
      end
      BODY: begin
        if (pop) begin
          load      = 1'b1;
          load_last = (word_cnt == CNT_LAST);
          timer_d   = '0;
          if (load_last) begin
            word_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt + 1'b1;
          end
        end else if (fifo.empty && TIMEOUT != 0) begin
          // The timer never passes TMR_LAST: reaching TIMEOUT hands over to PAD.
          if (timer == TMR_LAST) begin
            timer_d = '0;
            state_d = PAD;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load      = 1'b1;
          load_pad  = 1'b1;
          load_data = PAD_VALUE;
          load_last = (word_cnt == CNT_LAST);
          if (load_last) begin
            word_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      timer    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      pad_q    <= 1'b0;
    end else begin
      state    <= state_d;
      word_cnt <= word_cnt_d;
      timer    <= timer_d;
      valid_q  <= load || (valid_q && !m.ready);
      if (load) begin
        data_q  <= load_data;
        first_q <= load_first;
        last_q  <= load_last;
        pad_q   <= load_pad;
      end
    end
  end

  assign m.valid = valid_q;
  assign m.data  = data_q;
  assign m.first = first_q;
  assign m.last  = last_q;
  assign m.pad   = pad_q;

`ifdef FIFO_PKT_READER_STATS_EN
  logic accept;
  assign accept = valid_q && m.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      pad_count <= '0;
    end else begin
      if (accept && last_q) pkt_count <= pkt_count + 16'd1;
      if (accept && pad_q)  pad_count <= pad_count + 16'd1;
    end
  end
`else
  assign pkt_count = '0;
  assign pad_count = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader: three configurations (PKT_LEN=4/TIMEOUT=8, PKT_LEN=1, TIMEOUT=0)
// driven by directed and random stimulus, checked against a packet-level scoreboard.
module tb_fifo_pkt_reader;

  localparam int N = 3;
  localparam logic [7:0] PAD_V = 8'hA5;
`ifdef FIFO_PKT_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic [N-1:0] rst;
  logic [N-1:0] m_ready;
  logic [N-1:0] rd_en, valid, first, last, pad;
  logic [N-1:0][7:0]  mdata;
  logic [N-1:0][15:0] pkt_cnt, pad_cnt;

  // FIFO models: one circular buffer per DUT
  logic [7:0] mem [N][256];
  logic [7:0] wr_ptr [N];
  logic [7:0] rd_ptr [N] = '{default: 8'd0};

  // Scoreboard state
  logic [7:0] exp_q [N][$];
  int pos [N];
  bit padding [N];
  int mpkt [N], mpad [N], accepted [N];
  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    for (int k = 0; k < N; k++)
      if (rd_en[k]) rd_ptr[k] <= rd_ptr[k] + 8'd1;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int P = (g == 1) ? 1 : 4;
    localparam int T = (g == 2) ? 0 : 8;
    fifo_rd_if    #(.DATA_WIDTH(8)) f_if ();
    pkt_stream_if #(.DATA_WIDTH(8)) s_if ();
    assign f_if.empty  = (wr_ptr[g] == rd_ptr[g]);
    assign f_if.data   = mem[g][rd_ptr[g]];
    assign s_if.ready  = m_ready[g];
    assign rd_en[g]    = f_if.rd_en;
    assign valid[g]    = s_if.valid;
    assign mdata[g]    = s_if.data;
    assign first[g]    = s_if.first;
    assign last[g]     = s_if.last;
    assign pad[g]      = s_if.pad;
    fifo_pkt_reader #(.DATA_WIDTH(8), .PKT_LEN(P), .TIMEOUT(T), .PAD_VALUE(PAD_V)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .fifo      (f_if),
      .m         (s_if),
      .pkt_count (pkt_cnt[g]),
      .pad_count (pad_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pl_of(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  function automatic int occ(input int k);
    logic [7:0] d;
    d = wr_ptr[k] - rd_ptr[k];
    return int'(d);
  endfunction

  task automatic push(input int k, input logic [7:0] v);
    mem[k][wr_ptr[k]] = v;
    wr_ptr[k] = wr_ptr[k] + 8'd1;
    exp_q[k].push_back(v);
  endtask

  // Reset discards whatever the DUT held; expected words are those still in the FIFO.
  task automatic model_reset(input int k);
    logic [7:0] idx;
    exp_q[k].delete();
    for (int i = 0; i < occ(k); i++) begin
      idx = rd_ptr[k] + 8'(i);
      exp_q[k].push_back(mem[k][idx]);
    end
    pos[k] = 0;
    padding[k] = 1'b0;
    mpkt[k] = 0;
    mpad[k] = 0;
  endtask

  task automatic score(input int k);
    int pl;
    pl = pl_of(k);
    if (k == 2) check("k2_pad_disabled", pad[k], 1'b0);
    if (padding[k]) check($sformatf("k%0d_pad_tail", k), pad[k], 1'b1);
    if (pad[k]) begin
      check($sformatf("k%0d_pad_data", k), mdata[k], PAD_V);
      check($sformatf("k%0d_pad_mid", k), pos[k] != 0, 1'b1);
      padding[k] = 1'b1;
      mpad[k]++;
    end else begin
      check($sformatf("k%0d_word_expected", k), exp_q[k].size() != 0, 1'b1);
      if (exp_q[k].size() != 0)
        check($sformatf("k%0d_data", k), mdata[k], exp_q[k].pop_front());
    end
    check($sformatf("k%0d_first", k), first[k], pos[k] == 0);
    check($sformatf("k%0d_last", k), last[k], pos[k] == pl - 1);
    if (pos[k] == pl - 1) begin
      pos[k] = 0;
      padding[k] = 1'b0;
      mpkt[k]++;
    end else begin
      pos[k]++;
    end
    accepted[k]++;
  endtask

  task automatic tick();
    logic [N-1:0] rst_edge;
    rst_edge = rst;
    for (int k = 0; k < N; k++)
      if (!rst[k] && valid[k] && m_ready[k]) score(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (rst_edge[k]) model_reset(k);
  endtask

  task automatic check_stats(input int k);
    check($sformatf("k%0d_pkt_count", k), pkt_cnt[k], STATS ? 16'(mpkt[k]) : 16'd0);
    check($sformatf("k%0d_pad_count", k), pad_cnt[k], STATS ? 16'(mpad[k]) : 16'd0);
  endtask

  function automatic bit drained();
    for (int k = 0; k < N; k++)
      if (exp_q[k].size() != 0 || valid[k]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    rst = '1;
    m_ready = '1;
    for (int k = 0; k < N; k++) begin
      wr_ptr[k] = 8'd0;
      pos[k] = 0;
      accepted[k] = 0;
    end
    for (int i = 1; i <= 8; i++) push(0, 8'(i));
    repeat (3) tick();

    // Reset state, including no pop while rst is held with a non-empty FIFO
    for (int k = 0; k < N; k++) begin
      check($sformatf("k%0d_rst_valid", k), valid[k], 1'b0);
      check($sformatf("k%0d_rst_data", k), mdata[k], 8'h00);
      check($sformatf("k%0d_rst_flags", k), {first[k], last[k], pad[k]}, 3'b000);
      check($sformatf("k%0d_rst_rd_en", k), rd_en[k], 1'b0);
      check_stats(k);
    end
    check("k0_rst_no_pop", occ(0), 8);

    // Eight preloaded words stream back-to-back as two packets
    rst = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("a_valid", valid[0], 1'b1);
      check("a_data", mdata[0], 8'(i + 1));
      check("a_first", first[0], (i % 4) == 0);
      check("a_last", last[0], (i % 4) == 3);
    end
    tick();
    check("a_valid_end", valid[0], 1'b0);
    check_stats(0);

    // Stall mid-packet: 8 idle cycles, then two pad words; a word pushed in PAD waits for IDLE
    push(0, 8'h10);
    push(0, 8'h11);
    tick();
    check("b_data0", mdata[0], 8'h10);
    check("b_first0", first[0], 1'b1);
    tick();
    check("b_data1", mdata[0], 8'h11);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b_idle_valid", valid[0], 1'b0);
    end
    push(0, 8'h20);
    tick();
    check("b_pad0_valid", valid[0], 1'b1);
    check("b_pad0", {mdata[0], pad[0], last[0]}, {PAD_V, 1'b1, 1'b0});
    check("b_pad0_no_pop", occ(0), 1);
    tick();
    check("b_pad1", {mdata[0], pad[0], last[0]}, {PAD_V, 1'b1, 1'b1});
    check("b_pad1_no_pop", occ(0), 1);
    tick();
    check("b_after_pad", {mdata[0], first[0], pad[0]}, {8'h20, 1'b1, 1'b0});
    check("b_after_pad_pop", occ(0), 0);
    push(0, 8'h21);
    push(0, 8'h22);
    push(0, 8'h23);
    repeat (3) tick();
    check("b_tail", {mdata[0], last[0]}, {8'h23, 1'b1});
    tick();
    check_stats(0);

    // Backpressure: outputs hold and nothing is popped while m_ready is low
    for (int i = 0; i < 8; i++) push(0, 8'(8'h30 + i));
    tick();
    check("c_data0", mdata[0], 8'h30);
    m_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_hold", {valid[0], mdata[0], first[0], last[0], pad[0]}, {1'b1, 8'h30, 3'b100});
      check("c_rd_en", rd_en[0], 1'b0);
      check("c_occ", occ(0), 7);
    end
    m_ready[0] = 1'b1;
    tick();
    check("c_resume", mdata[0], 8'h31);
    for (int i = 0; i < 20 && exp_q[0].size() != 0; i++) tick();
    check("c_drained", exp_q[0].size(), 0);
    tick();

    // Reset after two words of a packet
    for (int i = 0; i < 4; i++) push(0, 8'(8'h40 + i));
    tick();
    tick();
    check("e_pre_rst", mdata[0], 8'h41);
    rst[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e_rst_valid", valid[0], 1'b0);
      check("e_rst_no_pop", occ(0), 2);
    end
    rst[0] = 1'b0;
    tick();
    check("e_restart", {valid[0], mdata[0], first[0]}, {1'b1, 8'h42, 1'b1});
    push(0, 8'h44);
    push(0, 8'h45);
    for (int i = 0; i < 20 && exp_q[0].size() != 0; i++) tick();
    check("e_drained", exp_q[0].size(), 0);
    check_stats(0);

    // TIMEOUT=0: a stalled packet waits indefinitely without padding
    push(2, 8'h50);
    push(2, 8'h51);
    repeat (3) tick();
    vcnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid[2]) vcnt++;
    end
    check("f_no_pad_while_empty", vcnt, 0);
    push(2, 8'h52);
    push(2, 8'h53);
    tick();
    tick();
    check("f_complete", {mdata[2], last[2], pad[2]}, {8'h53, 1'b1, 1'b0});
    tick();
    check_stats(2);

    // Random traffic on all three configurations, with quiet windows to provoke padding
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        int unsigned rate;
        rate = (((c / 40) % 3) == 2) ? 0 : 2;
        if ($urandom_range(0, 3) < rate && occ(k) < 200) push(k, 8'($urandom));
        m_ready[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    m_ready = '1;
    for (int i = 0; i < 300 && !drained(); i++) tick();
    check("rand_drained", drained(), 1'b1);
    for (int k = 0; k < N; k++) check_stats(k);
    check("pl1_pkt_eq_words", pkt_cnt[1], STATS ? 16'(accepted[1]) : 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
